// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   master side (issuer)  drives in_valid, a, b, is_shift, scode, acode,
//                         flag_clr, out_ready; observes in_ready and results.
//   slave side (alu_seq)  drives in_ready, out_valid, r, carry_out, overflow,
//                         negative, zero, c_flag.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_shift;
  logic [1:0]       scode;
  logic [2:0]       acode;
  logic             flag_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             carry_out;
  logic             overflow;
  logic             negative;
  logic             zero;
  logic             c_flag;

  modport master (
    output in_valid, a, b, is_shift, scode, acode, flag_clr, out_ready,
    input  in_ready, out_valid, r, carry_out, overflow, negative, zero, c_flag
  );

  modport slave (
    input  in_valid, a, b, is_shift, scode, acode, flag_clr, out_ready,
    output in_ready, out_valid, r, carry_out, overflow, negative, zero, c_flag
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with an internal carry flag and a
// 1-bit-per-cycle serial shifter.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         alu_seq_if slave port:
//                 in_valid/in_ready   request handshake
//                 a, b                operands (b low SHAMT_W bits = shift amount)
//                 is_shift/scode/acode operation select
//                 flag_clr            clears the internal carry flag C
//                 out_valid/out_ready result handshake
//                 r, carry_out, overflow, negative, zero  registered result/flags
//                 c_flag              current C flag
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRA, SH_ROR, SH_ROL} sop_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_NOT
  } aop_t;

  state_t             state, state_d;
  sop_t               sop;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   r_q;
  logic               carry_q, ovf_q, neg_q, zero_q, c_q;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  aop_t               aop;

  logic [WIDTH-1:0]   b_op;
  logic               c_in;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;

  logic [WIDTH-1:0]   sh_next;
  logic               sh_bit;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.r         = r_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.c_flag    = c_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign shamt  = bus.b[SHAMT_W-1:0];
  assign aop    = aop_t'(bus.acode);

  // Arithmetic is one adder: subtraction inverts b, and the carry-in is
  // 0 (ADD), 1 (SUB) or C (ADC/SBC). flag_clr forces C to 0 for this op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    b_op  = bus.acode[1] ? ~bus.b : bus.b;
    c_in  = bus.acode[0] ? (c_q && !bus.flag_clr) : bus.acode[1];
    sum   = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_in};
    unique case (aop)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        // Same-sign operands producing a different-sign result.
        alu_v = (bus.a[WIDTH-1] == b_op[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_r = bus.a & bus.b;
      OP_OR:   alu_r = bus.a | bus.b;
      OP_XOR:  alu_r = bus.a ^ bus.b;
      OP_NOT:  alu_r = ~bus.a;
      default: alu_r = '0;
    endcase
  end

  // One step of the serial shifter; sh_bit is the bit leaving the word.
  always_comb begin
    sh_next = work;
    sh_bit  = 1'b0;
    unique case (sop)
      SH_SLL: begin
        sh_next = {work[WIDTH-2:0], 1'b0};
        sh_bit  = work[WIDTH-1];
      end
      SH_SRA: begin
        sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
        sh_bit  = work[0];
      end
      SH_ROR:  sh_next = {work[0], work[WIDTH-1:1]};
      SH_ROL:  sh_next = {work[WIDTH-2:0], work[WIDTH-1]};
      default: sh_next = work;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_d = (bus.is_shift && shamt != '0) ? SHIFT : DONE;
        end else if (state == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT:   if (cnt == SHAMT_W'(1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop     <= SH_SLL;
      work    <= '0;
      cnt     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      if (accept) begin
        if (bus.is_shift) begin
          if (shamt == '0) begin
            r_q     <= bus.a;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= bus.a[WIDTH-1];
            zero_q  <= (bus.a == '0);
          end else begin
            // The previous result stays on r; out_valid is low while shifting.
            work <= bus.a;
            cnt  <= shamt;
            sop  <= sop_t'(bus.scode);
          end
        end else begin
          r_q     <= alu_r;
          carry_q <= alu_c;
          ovf_q   <= alu_v;
          neg_q   <= alu_r[WIDTH-1];
          zero_q  <= (alu_r == '0);
        end
      end else if (state == SHIFT) begin
        work <= sh_next;
        cnt  <= cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          r_q     <= sh_next;
          carry_q <= (sop == SH_SLL || sop == SH_SRA) ? sh_bit : 1'b0;
          ovf_q   <= 1'b0;
          neg_q   <= sh_next[WIDTH-1];
          zero_q  <= (sh_next == '0);
        end
      end

      // C follows arithmetic results only; otherwise flag_clr clears it.
      if (accept && !bus.is_shift && !bus.acode[2]) c_q <= alu_c;
      else if (bus.flag_clr)                         c_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected results are computed by a behavioural model at
// accept time, queued, and compared when the result is consumed.
module tb_alu_seq;

  typedef struct {
    logic [7:0] r;
    logic       co;
    logic       v;
    logic       c;
    int         acc;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  logic c_model;
  logic seen;
  int   first_cyc;
  exp_t sb[$];

  // current op held on the bus, used by the model at accept time
  logic       op_sh;
  logic [1:0] op_sc;
  logic [2:0] op_ac;
  logic [7:0] op_a, op_b;
  logic       op_fc;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural reference: integer arithmetic and bit-at-a-time shifting.
  function automatic exp_t model(input logic sh, input logic [1:0] sc,
                                 input logic [2:0] ac, input logic [7:0] a,
                                 input logic [7:0] b, input logic fc);
    exp_t e;
    int ua, ub, sa, sb_i, cin, borrow, res, sres, n;
    logic [7:0] v;
    e.co = 1'b0; e.v = 1'b0; e.lat = 0; e.acc = 0;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb_i = int'($signed(b));
    cin = (c_model && !fc) ? 1 : 0;
    if (sh) begin
      n = int'(b) % 8;
      v = a;
      for (int i = 0; i < n; i++) begin
        case (sc)
          2'd0: begin e.co = v[7]; v = v << 1; end
          2'd1: begin e.co = v[0]; v = $signed(v) >>> 1; end
          2'd2: begin e.co = 1'b0; v = (v >> 1) | (v << 7); end
          default: begin e.co = 1'b0; v = (v << 1) | (v >> 7); end
        endcase
      end
      if (sc[1]) e.co = 1'b0;
      e.r = v;
      e.lat = n;
    end else begin
      case (ac)
        3'd0, 3'd1: begin
          if (ac == 3'd0) cin = 0;
          res = ua + ub + cin; sres = sa + sb_i + cin;
          e.r = 8'(res); e.co = (res > 255);
          e.v = (sres > 127) || (sres < -128);
        end
        3'd2, 3'd3: begin
          borrow = (ac == 3'd2) ? 0 : 1 - cin;
          res = ua - ub - borrow; sres = sa - sb_i - borrow;
          e.r = 8'(res); e.co = (ua >= ub + borrow);
          e.v = (sres > 127) || (sres < -128);
        end
        3'd4: e.r = a & b;
        3'd5: e.r = a | b;
        3'd6: e.r = a ^ b;
        default: e.r = ~a;
      endcase
    end
    if (!sh && !ac[2]) c_model = e.co;
    else if (fc)       c_model = 1'b0;
    e.c = c_model;
    return e;
  endfunction

  // Called 1 unit after a rising edge.
  task automatic drive(input logic sh, input logic [1:0] sc, input logic [2:0] ac,
                       input logic [7:0] a, input logic [7:0] b, input logic fc);
    op_sh = sh; op_sc = sc; op_ac = ac; op_a = a; op_b = b; op_fc = fc;
    bus.is_shift = sh; bus.scode = sc; bus.acode = ac;
    bus.a = a; bus.b = b; bus.flag_clr = fc;
    bus.in_valid = 1'b1;
  endtask

  // Waits (bounded) for the held op to be accepted; returns 1 unit after
  // the accepting edge with in_valid dropped.
  task automatic wait_accept(output int acc);
    exp_t e;
    bit   done;
    done = 0;
    acc  = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(op_sh, op_sc, op_ac, op_a, op_b, op_fc);
        acc   = cyc + 1;
        e.acc = acc;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flag_clr = 1'b0;
    if (!done) check("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic send(input logic sh, input logic [1:0] sc, input logic [2:0] ac,
                      input logic [7:0] a, input logic [7:0] b, input logic fc,
                      output int acc);
    drive(sh, sc, ac, a, b, fc);
    wait_accept(acc);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  // Result monitor: latency is measured from the accepting edge to the first
  // falling edge with out_valid; values are compared when consumed.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (!seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_ready) begin
        check("result_expected", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("r",         32'(bus.r),         32'(e.r));
          check("carry_out", 32'(bus.carry_out), 32'(e.co));
          check("overflow",  32'(bus.overflow),  32'(e.v));
          check("negative",  32'(bus.negative),  32'(e.r[7]));
          check("zero",      32'(bus.zero),      32'(e.r == 8'h00));
          check("c_flag",    32'(bus.c_flag),    32'(e.c));
          check("latency",   32'(first_cyc - e.acc), 32'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    int acc0, acc1, rise_cyc;
    logic [7:0] held_r;
    n_checks = 0; n_pass = 0; c_model = 1'b0; seen = 1'b0; first_cyc = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_shift = 1'b0;
    bus.scode = '0; bus.acode = '0; bus.flag_clr = 1'b0; bus.out_ready = 1'b1;
    op_sh = 1'b0; op_sc = '0; op_ac = '0; op_a = '0; op_b = '0; op_fc = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_r",         32'(bus.r),         32'(0));
    check("rst_carry",     32'(bus.carry_out), 32'(0));
    check("rst_overflow",  32'(bus.overflow),  32'(0));
    check("rst_negative",  32'(bus.negative),  32'(0));
    check("rst_zero",      32'(bus.zero),      32'(0));
    check("rst_c_flag",    32'(bus.c_flag),    32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 0x7F+0x01: signed overflow into 0x80
    send(1'b0, 2'd0, 3'd0, 8'h7F, 8'h01, 1'b0, acc0);
    drain();

    // Back-to-back SUB then SBC
    drive(1'b0, 2'd0, 3'd2, 8'h00, 8'h01, 1'b0);
    wait_accept(acc0);
    drive(1'b0, 2'd0, 3'd3, 8'h01, 8'h00, 1'b0);
    wait_accept(acc1);
    check("back_to_back", 32'(acc1 - acc0), 32'(1));
    drain();

    // Serial shifts
    send(1'b1, 2'd2, 3'd0, 8'h81, 8'd1, 1'b0, acc0);   // ROR 1
    send(1'b1, 2'd3, 3'd0, 8'h81, 8'd3, 1'b0, acc0);   // ROL 3
    send(1'b1, 2'd1, 3'd0, 8'h80, 8'd7, 1'b0, acc0);   // SRA 7
    @(negedge clk);
    check("shift_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk); #1;
    drain();

    // Masked shift amount, then SLL carry-out with C left alone
    send(1'b1, 2'd0, 3'd0, 8'h5A, 8'h08, 1'b0, acc0);
    send(1'b1, 2'd0, 3'd0, 8'h81, 8'd1, 1'b0, acc0);
    drain();

    // Logic ops
    send(1'b0, 2'd0, 3'd4, 8'hF0, 8'h3C, 1'b0, acc0);
    send(1'b0, 2'd0, 3'd7, 8'hFF, 8'h00, 1'b0, acc0);
    drain();

    // Backpressure: hold ADD result while the next op waits
    bus.out_ready = 1'b0;
    send(1'b0, 2'd0, 3'd0, 8'h10, 8'h20, 1'b0, acc0);
    drive(1'b0, 2'd0, 3'd6, 8'hF0, 8'h0F, 1'b0);
    held_r = 8'h30;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'(1));
      check("bp_in_ready",  32'(bus.in_ready),  32'(0));
      check("bp_r",         32'(bus.r),         32'(held_r));
      check("bp_carry",     32'(bus.carry_out), 32'(0));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    rise_cyc = cyc + 1;
    wait_accept(acc1);
    check("bp_same_cycle_accept", 32'(acc1), 32'(rise_cyc));
    drain();

    // flag_clr forces C=0 into ADC
    send(1'b0, 2'd0, 3'd0, 8'hFF, 8'h01, 1'b0, acc0);  // C=1
    send(1'b0, 2'd0, 3'd1, 8'h01, 8'h01, 1'b1, acc0);  // 0x02, C=0
    send(1'b0, 2'd0, 3'd0, 8'hFF, 8'h01, 1'b0, acc0);  // C=1 again
    drain();

    // Reset in the middle of a 5-bit shift
    send(1'b1, 2'd0, 3'd0, 8'h01, 8'd5, 1'b0, acc0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_in_ready",  32'(bus.in_ready),  32'(1));
    check("midrst_c_flag",    32'(bus.c_flag),    32'(0));
    sb.delete();
    c_model = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b0, 2'd0, 3'd1, 8'h01, 8'h01, 1'b0, acc0);  // ADC -> 0x02
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
